// File: rtl/aes_pkg.sv
// Shared AES types, constants and GF(2^8) helpers for the key schedule.
package aes_pkg;

   localparam int unsigned AES_NR  = 10;
   localparam int unsigned WORD_W  = 32;
   localparam int unsigned KEY_W   = 128;
   localparam int unsigned ROUND_W = 4;
   localparam logic [7:0]  RCON_INIT = 8'h01;
   localparam logic [7:0]  RCON_POLY = 8'h1b;

   typedef logic [WORD_W-1:0] word_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD,
      ST_RUN,
      ST_FIN
   } state_e;

   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? RCON_POLY : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] aa;
      p  = 8'h00;
      aa = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ aa;
         aa = xtime(aa);
      end
      return p;
   endfunction

   // Multiplicative inverse as a^254 (maps 0 to 0 as the S-box requires).
   function automatic logic [7:0] gf_inv(input logic [7:0] a);
      logic [7:0] r;
      logic [7:0] e;
      r = 8'h01;
      e = 8'hfe;
      for (int i = 7; i >= 0; i--) begin
         r = gf_mul(r, r);
         if (e[i]) r = gf_mul(r, a);
      end
      return r;
   endfunction

   function automatic logic [7:0] sbox(input logic [7:0] a);
      logic [7:0] b;
      b = gf_inv(a);
      return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
               ^ {b[3:0], b[7:4]} ^ 8'h63;
   endfunction

endpackage

// File: rtl/aes_key_expand_subword.sv
// SubWord: four parallel AES S-boxes, purely combinational.
module aes_key_expand_subword
   import aes_pkg::*;
(
   input  logic [7:0] S0_in,
   input  logic [7:0] S1_in,
   input  logic [7:0] S2_in,
   input  logic [7:0] S3_in,
   output logic [7:0] D0_out,
   output logic [7:0] D1_out,
   output logic [7:0] D2_out,
   output logic [7:0] D3_out
);

   assign D0_out = sbox(S0_in);
   assign D1_out = sbox(S1_in);
   assign D2_out = sbox(S2_in);
   assign D3_out = sbox(S3_in);

endmodule

// File: rtl/aes_key_expand.sv
// Iterative AES-128 key schedule: one round key per accepted valid/ready beat.
module aes_key_expand
   import aes_pkg::*;
#(
   parameter int unsigned NR = AES_NR
)(
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [127:0] key_in,
   input  logic         rk_ready,
   output logic         busy,
   output logic         rk_valid,
   output logic [3:0]   rk_round,
   output logic [127:0] rk_out,
   output logic         done
);

   state_e             state_q, state_d;
   logic [KEY_W-1:0]   key_q, key_d;
   logic [KEY_W-1:0]   rk_out_q, rk_out_d;
   logic [ROUND_W-1:0] rk_round_q, rk_round_d;
   logic               rk_valid_q, rk_valid_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic [7:0]         rcon_q, rcon_d;

   word_t w0, w1, w2, w3;
   word_t rot_w, sub_w, t_w;
   word_t nw0, nw1, nw2, nw3;
   logic  beat;
   logic  last;

   // Next-key datapath straight off the registered round key.
   assign {w0, w1, w2, w3} = rk_out_q;
   assign rot_w = {w3[23:0], w3[31:24]};

   aes_key_expand_subword u_subword (
      .S0_in  (rot_w[31:24]),
      .S1_in  (rot_w[23:16]),
      .S2_in  (rot_w[15:8]),
      .S3_in  (rot_w[7:0]),
      .D0_out (sub_w[31:24]),
      .D1_out (sub_w[23:16]),
      .D2_out (sub_w[15:8]),
      .D3_out (sub_w[7:0])
   );

   assign t_w = sub_w ^ {rcon_q, 24'h000000};
   assign nw0 = w0 ^ t_w;
   assign nw1 = w1 ^ nw0;
   assign nw2 = w2 ^ nw1;
   assign nw3 = w3 ^ nw2;

   assign beat = rk_valid_q & rk_ready;
   assign last = (rk_round_q == ROUND_W'(NR));

   always_comb begin
      state_d    = state_q;
      key_d      = key_q;
      rk_out_d   = rk_out_q;
      rk_round_d = rk_round_q;
      rk_valid_d = rk_valid_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      rcon_d     = rcon_q;
      case (state_q)
         ST_IDLE: begin
            busy_d = 1'b0;
            if (start) begin
               state_d = ST_LOAD;
               key_d   = key_in;
               busy_d  = 1'b1;
            end
         end
         ST_LOAD: begin
            state_d    = ST_RUN;
            rk_out_d   = key_q;
            rk_round_d = '0;
            rk_valid_d = 1'b1;
            rcon_d     = RCON_INIT;
            busy_d     = 1'b1;
         end
         ST_RUN: begin
            if (beat) begin
               if (last) begin
                  // Final beat: drop valid and busy together with the done pulse.
                  state_d    = ST_FIN;
                  rk_valid_d = 1'b0;
                  busy_d     = 1'b0;
                  done_d     = 1'b1;
               end else begin
                  rk_out_d   = {nw0, nw1, nw2, nw3};
                  rk_round_d = rk_round_q + ROUND_W'(1);
                  rcon_d     = xtime(rcon_q);
               end
            end
         end
         ST_FIN: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         key_q      <= '0;
         rk_out_q   <= '0;
         rk_round_q <= '0;
         rk_valid_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         rcon_q     <= RCON_INIT;
      end else begin
         state_q    <= state_d;
         key_q      <= key_d;
         rk_out_q   <= rk_out_d;
         rk_round_q <= rk_round_d;
         rk_valid_q <= rk_valid_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         rcon_q     <= rcon_d;
      end
   end

   assign busy     = busy_q;
   assign rk_valid = rk_valid_q;
   assign rk_round = rk_round_q;
   assign rk_out   = rk_out_q;
   assign done     = done_q;

endmodule

// File: tb/tb_aes_key_expand.sv
// Bench for aes_key_expand: reference key schedule built from a generated S-box table.
module tb_aes_key_expand;

   logic         clk;
   logic         rst_n;
   logic         start;
   logic [127:0] key_in;
   logic         rk_ready;
   logic         busy;
   logic         rk_valid;
   logic [3:0]   rk_round;
   logic [127:0] rk_out;
   logic         done;

   int n_cmp = 0;
   int n_err = 0;

   logic [7:0]   sbox_t [256];
   logic [127:0] exp_rk [11];

   localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] FIPS_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
   localparam logic [127:0] FIPS_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
   localparam logic [127:0] KEY2     = 128'h5468617473206d79204b756e67204675;
   localparam logic [127:0] KEY2_R1  = 128'he232fcf191129188b159e4e6d679a293;
   localparam logic [127:0] KEY2_R10 = 128'h28fddef86da4244accc0a4fe3b316f26;

   aes_key_expand dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .key_in   (key_in),
      .rk_ready (rk_ready),
      .busy     (busy),
      .rk_valid (rk_valid),
      .rk_round (rk_round),
      .rk_out   (rk_out),
      .done     (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
      logic [15:0] t;
      t = {v, v} << n;
      return t[15:8];
   endfunction

   // S-box table from the p = 3^k / q = 3^-k walk plus the affine map.
   task automatic build_sbox();
      logic [7:0] p, q, x;
      p = 8'h01;
      q = 8'h01;
      do begin
         p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
         q = q ^ {q[6:0], 1'b0};
         q = q ^ {q[5:0], 2'b00};
         q = q ^ {q[3:0], 4'h0};
         if (q[7]) q = q ^ 8'h09;
         x = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4) ^ 8'h63;
         sbox_t[p] = x;
      end while (p != 8'h01);
      sbox_t[0] = 8'h63;
   endtask

   task automatic model_expand(input logic [127:0] key);
      logic [31:0] w [44];
      logic [7:0]  rc [10];
      logic [31:0] t;
      rc = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
      for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t = {t[23:0], t[31:24]};
            t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]};
            t = t ^ {rc[i/4 - 1], 24'h000000};
         end
         w[i] = w[i-4] ^ t;
      end
      for (int r = 0; r < 11; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   endtask

   function automatic logic [127:0] rand128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // Called at a negedge; drives one full expansion and checks every presented key.
   task automatic run_seq(input logic [127:0] key, input bit bp, input bit inject,
                          input int abort_at, input bit use_vec,
                          input logic [127:0] v1, input logic [127:0] v10);
      int idx;
      int iter;
      model_expand(key);
      start  = 1'b1;
      key_in = key;
      @(posedge clk); @(negedge clk);
      start  = 1'b0;
      key_in = rand128();
      chk("load_busy", 128'(busy), 128'(1));
      chk("load_valid", 128'(rk_valid), 128'(0));
      idx  = 0;
      iter = 0;
      while (idx <= 10 && iter < 300) begin
         @(posedge clk); @(negedge clk);
         start = 1'b0;
         chk("valid", 128'(rk_valid), 128'(1));
         chk("busy", 128'(busy), 128'(1));
         chk("round", 128'(rk_round), 128'(idx));
         chk("rk", rk_out, exp_rk[idx]);
         if (use_vec && idx == 1)  chk("vec_r1", rk_out, v1);
         if (use_vec && idx == 10) chk("vec_r10", rk_out, v10);
         if (!bp && idx == 10)     chk("latency", 128'(iter), 128'(10));
         if (idx == abort_at) return;
         if (inject && iter == 3) begin
            start  = 1'b1;
            key_in = rand128();
         end
         rk_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
         iter++;
         if (rk_ready) idx++;
      end
      chk("rounds_seen", 128'(idx), 128'(11));
      @(posedge clk); @(negedge clk);
      start = 1'b0;
      chk("done_pulse", 128'(done), 128'(1));
      chk("done_busy", 128'(busy), 128'(0));
      chk("done_valid", 128'(rk_valid), 128'(0));
      @(posedge clk); @(negedge clk);
      chk("done_clear", 128'(done), 128'(0));
      chk("idle_busy", 128'(busy), 128'(0));
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_busy"},  128'(busy), 128'(0));
      chk({tag, "_valid"}, 128'(rk_valid), 128'(0));
      chk({tag, "_round"}, 128'(rk_round), 128'(0));
      chk({tag, "_rk"},    rk_out, 128'(0));
      chk({tag, "_done"},  128'(done), 128'(0));
   endtask

   initial begin
      rst_n    = 1'b0;
      start    = 1'b0;
      key_in   = '0;
      rk_ready = 1'b0;
      build_sbox();
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_reset_outputs("reset");
      rst_n = 1'b1;
      @(negedge clk);

      run_seq(FIPS_KEY, 1'b0, 1'b0, -1, 1'b1, FIPS_R1, FIPS_R10);
      // Back-to-back: start issued the cycle after done.
      run_seq(KEY2, 1'b0, 1'b0, -1, 1'b1, KEY2_R1, KEY2_R10);
      run_seq(FIPS_KEY, 1'b1, 1'b0, -1, 1'b1, FIPS_R1, FIPS_R10);
      run_seq(FIPS_KEY, 1'b0, 1'b1, -1, 1'b1, FIPS_R1, FIPS_R10);
      for (int i = 0; i < 4; i++)
         run_seq(rand128(), 1'(i % 2), 1'b0, -1, 1'b0, '0, '0);

      // Asynchronous reset in the middle of an expansion.
      rk_ready = 1'b1;
      run_seq(FIPS_KEY, 1'b0, 1'b0, 5, 1'b0, '0, '0);
      rst_n = 1'b0;
      #1;
      chk_reset_outputs("async_rst");
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); @(negedge clk);
         chk("rst_no_done", 128'(done), 128'(0));
      end
      rst_n = 1'b1;
      @(negedge clk);
      run_seq(FIPS_KEY, 1'b0, 1'b0, -1, 1'b1, FIPS_R1, FIPS_R10);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
      $fatal(1, "watchdog");
   end

endmodule
